// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int unsigned CH_AES = 0;
  localparam int unsigned CH_SHA = 1;

  // Bytes per transfer for an address width plus an 8-bit command byte.
  function automatic int unsigned nbeat_f(input int unsigned addrw);
    return (addrw + 8) / 8;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Requester/bus bundle for bus_arbiter_rr; timeout_err exists only with BUS_ARB_TIMEOUT_EN.
interface bus_arbiter_rr_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned ADDRW = 24
) ();
  import bus_arb_pkg::*;

  localparam int unsigned W     = ADDRW + 8;
  localparam int unsigned NBEAT = nbeat_f(ADDRW);
  localparam int unsigned BCW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  logic [NCH-1:0]   req;
  logic [NCH*W-1:0] data_in;
  logic             bus_ready;
  logic [7:0]       data_out;
  logic             valid_out;
  logic [NCH-1:0]   grant;
  logic [NCH-1:0]   done;
  logic [BCW-1:0]   beat_cnt;
  logic             busy;
`ifdef BUS_ARB_TIMEOUT_EN
  logic             timeout_err;

  modport master (
    input  req, data_in, bus_ready,
    output data_out, valid_out, grant, done, beat_cnt, busy, timeout_err
  );
  modport slave (
    output req, data_in, bus_ready,
    input  data_out, valid_out, grant, done, beat_cnt, busy, timeout_err
  );
`else
  modport master (
    input  req, data_in, bus_ready,
    output data_out, valid_out, grant, done, beat_cnt, busy
  );
  modport slave (
    output req, data_in, bus_ready,
    input  data_out, valid_out, grant, done, beat_cnt, busy
  );
`endif

endinterface

// File: rtl/bus_arbiter_rr_rr_pick.sv
// Round-robin winner select: lowest request at or above ptr_i, else lowest overall.
module rr_pick #(
  parameter int unsigned NCH = 4
) (
  input  logic [NCH-1:0]         req_i,
  input  logic [$clog2(NCH)-1:0] ptr_i,
  output logic [NCH-1:0]         gnt_c,
  output logic                   found_c
);

  logic [NCH-1:0] hi_mask;
  logic [NCH-1:0] masked;
  logic [NCH-1:0] sel;

  // Channels at or above the pointer get first claim; wrap to the bottom otherwise.
  assign hi_mask = ~((NCH'(1) << ptr_i) - NCH'(1));
  assign masked  = req_i & hi_mask;
  assign sel     = (|masked) ? masked : req_i;
  assign gnt_c   = sel & (~sel + NCH'(1));
  assign found_c = |req_i;

endmodule

// File: rtl/bus_arbiter_rr.sv
// N-channel round-robin arbiter serialising one request word per grant as byte beats.
// Optional stall watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned ADDRW = 24
`ifdef BUS_ARB_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 255
`endif
) (
  input logic              clk,
  input logic              rst_n,
  bus_arbiter_rr_if.master bus
);

  localparam int unsigned W     = ADDRW + 8;
  localparam int unsigned NBEAT = nbeat_f(ADDRW);
  localparam int unsigned BCW   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int unsigned PW    = $clog2(NCH);
  localparam int unsigned DW    = $clog2(NCH * W);

  state_e         state_q, state_d;
  logic [NCH-1:0] grant_q, grant_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [W-1:0]   shift_q, shift_d;
  logic [BCW-1:0] beat_q, beat_d;

  logic [NCH-1:0] win_c;
  logic           found_c;
  logic [PW-1:0]  win_idx_c;
  logic [W-1:0]   win_word_c;
  logic [PW-1:0]  next_ptr_c;
  logic [PW-1:0]  pick_ptr_c;
  logic           accept_c;
  logic           last_c;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned SW = $clog2(TIMEOUT + 1);
  logic [SW-1:0] stall_q, stall_d;
  logic          tmo_q, tmo_d;
`endif

  assign accept_c   = (state_q == ST_XFER) && bus.bus_ready;
  assign last_c     = accept_c && (beat_q == BCW'(NBEAT - 1));
  assign next_ptr_c = (owner_q == PW'(NCH - 1)) ? '0 : owner_q + PW'(1);
  // Re-arbitration on the last beat already sees the advanced pointer.
  assign pick_ptr_c = last_c ? next_ptr_c : ptr_q;

  rr_pick #(.NCH(NCH)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr_c),
    .gnt_c   (win_c),
    .found_c (found_c)
  );

  // Index and request word of the one-hot winner.
  always_comb begin
    win_idx_c  = '0;
    win_word_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (win_c[PW'(i)]) begin
        win_idx_c  = PW'(i);
        win_word_c = bus.data_in[DW'(i * W) +: W];
      end
    end
  end

  // Next-state logic; the shift register drains LSB byte first.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    shift_d = shift_q;
    beat_d  = beat_q;
`ifdef BUS_ARB_TIMEOUT_EN
    stall_d = stall_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (found_c) begin
          state_d = ST_XFER;
          grant_d = win_c;
          owner_d = win_idx_c;
          shift_d = win_word_c;
          beat_d  = '0;
        end
      end
      ST_XFER: begin
        if (accept_c) begin
          shift_d = shift_q >> 8;
          beat_d  = beat_q + BCW'(1);
`ifdef BUS_ARB_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_c) begin
            ptr_d  = next_ptr_c;
            beat_d = '0;
            if (found_c) begin
              grant_d = win_c;
              owner_d = win_idx_c;
              shift_d = win_word_c;
            end else begin
              state_d = ST_IDLE;
              grant_d = '0;
            end
          end
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else if (stall_q == SW'(TIMEOUT - 1)) begin
          // Abandon a stuck owner and give the next channel its turn.
          state_d = ST_IDLE;
          grant_d = '0;
          beat_d  = '0;
          shift_d = '0;
          ptr_d   = next_ptr_c;
          stall_d = '0;
          tmo_d   = 1'b1;
        end else begin
          stall_d = stall_q + SW'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      shift_q <= '0;
      beat_q  <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
      stall_q <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      shift_q <= shift_d;
      beat_q  <= beat_d;
`ifdef BUS_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign bus.data_out  = shift_q[7:0];
  assign bus.valid_out = (state_q == ST_XFER);
  assign bus.busy      = (state_q == ST_XFER);
  assign bus.grant     = grant_q;
  assign bus.beat_cnt  = beat_q;
  // done coincides with the accepted last beat of the owner.
  assign bus.done      = grant_q & {NCH{last_c}};
`ifdef BUS_ARB_TIMEOUT_EN
  assign bus.timeout_err = tmo_q;
`endif

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- N-channel round-robin bus arbiter; successor of the 2-channel AES/SHA arbiter.
- Serialises one (ADDRW+8)-bit request word per grant onto the shared 8-bit bus, LSB byte first.
- Each byte is a beat with a valid/ready handshake. Request words are captured at grant, so requesters may change data_in immediately afterwards.
- Sits between the crypto engine FSMs (AES, SHA, future cores) and the shared bus interface.

Parameters:
- NCH, 4, number of requesting channels (>=2); channel 0 = AES, channel 1 = SHA by system convention.
- ADDRW, 24, address width; request word width W = ADDRW+8, which must be a multiple of 8.
- NBEAT, derived localparam = W/8, bytes per transfer (4 at defaults).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NCH  per-channel request, level.
- data_in  in  NCH*W  packed request words; channel i occupies bits [i*W +: W].
- bus_ready  in  1  bus accepts the current beat.
- data_out  out  8  current beat byte.
- valid_out  out  1  beat valid.
- grant  out  NCH  one-hot owner of the bus, zero when idle.
- done  out  NCH  one-cycle one-hot pulse when the owner's last beat is accepted.
- beat_cnt  out  clog2(NBEAT)  index of the current beat.
- busy  out  1  transfer in progress.

Behaviour:
- Reset values: grant=0, done=0, valid_out=0, data_out=0, beat_cnt=0, busy=0, rr pointer=0 (channel 0 has top priority first).
- States:
  - IDLE: if any req is high at a clock edge, pick the winner, latch its word into shift_reg, set grant[winner], and go to XFER. Otherwise stay in IDLE.
  - XFER: valid_out=1, data_out = shift_reg byte[beat_cnt].
- Accepted beat = valid_out && bus_ready. On an accepted beat, beat_cnt increments. If bus_ready is low, data_out and beat_cnt hold and valid_out stays high.
- Last beat (beat_cnt == NBEAT-1) accepted:
  - pulse done[owner];
  - move the rr pointer to owner+1 mod NCH;
  - re-arbitrate in the same cycle, excluding nothing.
  - If any req is pending, latch the new winner and stay in XFER with beat_cnt=0 (back-to-back, zero bubble). Otherwise go to IDLE with grant=0.
- Winner selection: first asserted req scanning from the rr pointer upward with wrap-around (pointer NCH-1 wraps to 0). A single requester always wins regardless of the pointer.
- Latency: req seen at edge k gives grant and valid_out from cycle k+1. With bus_ready held high, done pulses at cycle k+NBEAT.
- Dropping req mid-transfer does not abort; the committed word completes. Asserting req on the current owner again re-requests, and that channel is eligible only after the other pending channels per rr order.
- Reset mid-transfer discards shift_reg contents and returns to IDLE. No partial-transfer indication.
- Outputs are registered or derived only from state, with no combinational path from req/data_in to outputs. The only combinational input dependency is bus_ready → beat advance.
- grant is never multi-hot. done occurs only in XFER.

Optional Feature:
- Macro BUS_ARB_TIMEOUT_EN.
- When defined:
  - adds parameter TIMEOUT (default 255) and output port timeout_err (1 bit, reset 0);
  - a stall counter counts consecutive XFER cycles with bus_ready low and clears on any accepted beat;
  - on reaching TIMEOUT: abort the transfer, pulse timeout_err for 1 cycle, do not pulse done, advance the rr pointer past the owner, return to IDLE.
- When undefined: no counter, no port; the arbiter waits indefinitely.

Decomposition:
- Shared package bus_arb_pkg:
  - state encoding (ST_IDLE, ST_XFER);
  - channel index constants CH_AES=0, CH_SHA=1;
  - function for the byte count from ADDRW.
- One sub-module: rr_pick. Combinational; takes req and pointer, returns a one-hot winner and a found flag; parametrised by NCH.

Test Plan:
- Single request: req=4'b0010, data_in ch1=32'hA1B2C3D4, bus_ready=1 -> grant=4'b0010 from next cycle; data_out B4? no: D4,C3,B2,A1 on 4 consecutive cycles; done[1] pulse on the 4th; then idle.
- Backpressure: same as above with bus_ready low for 3 cycles on beat 2 -> C3 held on data_out with valid_out=1 for 3 cycles; order intact; done delayed by 3 cycles.
- Fairness: req=4'b1111 held, bus_ready=1 -> grants 0,1,2,3,0 back-to-back with no idle cycle between transfers; each grant lasts exactly 4 cycles.
- Wrap/skip: pointer at 3, req=4'b0101 -> channel 0 served, then channel 2.
- Mid-operation events: req dropped after beat 1 -> transfer completes. rst_n low at beat 2 -> all outputs 0 immediately; first grant after reset goes to channel 0 when req=4'b0011.
- With BUS_ARB_TIMEOUT_EN and TIMEOUT=8: bus_ready held low -> timeout_err pulse after 8 stall cycles, no done, the next requester is granted.
